runahead_replay_queue: RTL

- Buffers 16-bit instructions captured during normal fetch and replays them, in order, into the runahead selection mux's runahead input.
- Sits directly upstream of the runahead selection mux and drives its runahead valid/instruction pair.
- While this block asserts valid, the mux stalls the fetched path. The block therefore owns the ordering and flow of replayed instructions.

---
 rtl/runahead_replay_queue.sv | 101 ++++++++++
 1 files changed

// File: rtl/runahead_replay_queue.sv
// Purpose: FIFO of instructions captured during normal fetch, replayed in order into the runahead mux input.
// Latency: ReplayStart in cycle N presents the head entry in cycle N+1; 1 instruction/cycle while not stalled.
// Backpressure: IssueStall freezes the presented entry; CaptureReady drops when full or while replaying.
module runahead_replay_queue #(
  parameter int DEPTH   = 8,
  parameter int INSTR_W = 16,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               sync_rst,
  input  logic               Flush,
  input  logic               CaptureValid,
  input  logic [INSTR_W-1:0] CaptureInstruction,
  output logic               CaptureReady,
  input  logic               ReplayStart,
  input  logic               IssueStall,
  output logic               RunaheadInstructionValid,
  output logic [INSTR_W-1:0] RunaheadInstruction,
  output logic               Replaying,
  output logic [ADDR_W:0]    Count
);

  typedef enum logic {CAPTURE = 1'b0, REPLAY = 1'b1} state_t;

  localparam logic [ADDR_W:0] FULL = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE  = (ADDR_W + 1)'(1);

  state_t             state;
  state_t             state_nxt;
  logic [INSTR_W-1:0] mem [DEPTH];
  logic [ADDR_W-1:0]  rd_ptr;
  logic [ADDR_W-1:0]  wr_ptr;
  logic [ADDR_W:0]    cnt;
  logic               cap_fire;
  logic               pop;

  // Handshake qualifiers; a capture offered alongside Flush is dropped.
  assign cap_fire = CaptureValid && CaptureReady && !Flush;
  assign pop      = RunaheadInstructionValid && !IssueStall;

  // State register.
  always_ff @(posedge clk) begin
    if (sync_rst) begin
      state <= CAPTURE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state: start replay if anything is (or is becoming) queued; leave after the last pop.
  always_comb begin
    state_nxt = state;
    if (Flush) begin
      state_nxt = CAPTURE;
    end else begin
      case (state)
        CAPTURE: if (ReplayStart && (cnt != '0 || cap_fire)) state_nxt = REPLAY;
        REPLAY:  if (cnt == '0 || (pop && cnt == ONE))       state_nxt = CAPTURE;
        default: state_nxt = CAPTURE;
      endcase
    end
  end

  // Outputs decoded from registered state and occupancy only.
  always_comb begin
    CaptureReady             = (state == CAPTURE) && (cnt != FULL);
    RunaheadInstructionValid = (state == REPLAY) && (cnt != '0);
    Replaying                = (state == REPLAY);
    RunaheadInstruction      = mem[rd_ptr];
    Count                    = cnt;
  end

  // Pointers and occupancy; captures and pops never coincide since they belong to different states.
  always_ff @(posedge clk) begin
    if (sync_rst || Flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (cap_fire) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      if (cap_fire) begin
        cnt <= cnt + 1'b1;
      end else if (pop) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

  // Entry storage; deliberately not reset.
  always_ff @(posedge clk) begin
    if (!sync_rst && cap_fire) begin
      mem[wr_ptr] <= CaptureInstruction;
    end
  end

endmodule
